// File: rtl/apb_master_arbiter.sv
// Two-port APB master: round-robin arbitration between two requesters onto one APB bus,
// with IDLE/SETUP/ACCESS sequencing and a wait-state timeout against hung slaves.
module apb_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_write,
    input  logic [3:0]            m0_stb,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_done,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_write,
    input  logic [3:0]            m1_stb,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_done,
    output logic                  m1_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perr,
    output logic                  busy
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Terminate in the ACCESS cycle that would be the TIMEOUT-th one with pready low.
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state;
    logic          gnt;
    logic          last_grant;
    logic [CW-1:0] wait_cnt;
    logic          elig0;
    logic          elig1;
    logic          pick1;

    // A port is masked while its done pulse is visible, since its requester still holds req.
    always_comb begin
        elig0 = m0_req & ~m0_done;
        elig1 = m1_req & ~m1_done;
        pick1 = elig1 & (~elig0 | ~last_grant);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            paddr      <= '0;
            pdata      <= '0;
            pwrite     <= 1'b0;
            pstb       <= 4'b0000;
            psel       <= 1'b0;
            penable    <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            m0_err  <= 1'b0;
            m1_err  <= 1'b0;
            case (state)
                IDLE: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    if (elig0 || elig1) begin
                        gnt        <= pick1;
                        last_grant <= pick1;
                        paddr      <= pick1 ? m1_addr  : m0_addr;
                        pdata      <= pick1 ? m1_wdata : m0_wdata;
                        pwrite     <= pick1 ? m1_write : m0_write;
                        if (pick1 ? m1_write : m0_write) begin
                            pstb <= pick1 ? m1_stb : m0_stb;
                        end else begin
                            pstb <= 4'b0000;
                        end
                        psel  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel     <= 1'b0;
                        penable  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= IDLE;
                        if (gnt) begin
                            m1_done <= 1'b1;
                            m1_err  <= perr;
                            if (!pwrite) begin
                                m1_rdata <= prdata;
                            end
                        end else begin
                            m0_done <= 1'b1;
                            m0_err  <= perr;
                            if (!pwrite) begin
                                m0_rdata <= prdata;
                            end
                        end
                    end else if (TIMEOUT > 0 && wait_cnt == TO_LAST) begin
                        // Hung slave: force an error completion and release the bus.
                        psel     <= 1'b0;
                        penable  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= IDLE;
                        if (gnt) begin
                            m1_done  <= 1'b1;
                            m1_err   <= 1'b1;
                            m1_rdata <= '0;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_err   <= 1'b1;
                            m0_rdata <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: scoreboard of expected completions plus
// cycle-accurate checks of APB phases, arbitration, wait states, errors, timeout and reset.
module tb_apb_master_arbiter;

    logic        pclk;
    logic        rst;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_write, m1_write;
    logic [3:0]  m0_stb, m1_stb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m1_done, m0_err, m1_err;
    logic [31:0] paddr, pdata, prdata;
    logic        pwrite, psel, penable, pready, perr, busy;
    logic [3:0]  pstb;

    logic        slave_hang;
    logic        slave_err;
    int          slave_wait;
    int          acc_cnt;

    int          checks;
    int          errors;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    exp_t sb_item;

    apb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .pclk(pclk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
        .m0_stb(m0_stb), .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
        .m1_stb(m1_stb), .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb),
        .psel(psel), .penable(penable), .prdata(prdata), .pready(pready),
        .perr(perr), .busy(busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Slave model: pready after slave_wait low ACCESS cycles, data derived from the address.
    always @(posedge pclk) acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;
    assign pready = psel && penable && !slave_hang && (acc_cnt >= slave_wait);
    assign prdata = paddr ^ 32'h5EAD_BEEF;
    assign perr   = slave_err;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic write,
                                 input logic [3:0] stb);
        if (port == 0) begin
            m0_addr = addr; m0_wdata = wdata; m0_write = write; m0_stb = stb; m0_req = 1'b1;
        end else begin
            m1_addr = addr; m1_wdata = wdata; m1_write = write; m1_stb = stb; m1_req = 1'b1;
        end
    endtask

    task automatic expectDone(input int port, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.port = port; e.rdata = rdata; e.err = err;
        sbq.push_back(e);
    endtask

    task automatic waitDone(input int port, input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if ((port == 0) ? m0_done : m1_done) begin
                seen = 1'b1;
                if (port == 0) m0_req = 1'b0;
                else           m1_req = 1'b0;
            end
        end
        checkOutput({tag, "_done_seen"}, seen, 1);
    endtask

    // Scoreboard side: every completion pops the oldest expectation.
    always @(negedge pclk) begin
        if (!rst && (m0_done || m1_done)) begin
            checkOutput("sb_both_done", m0_done & m1_done, 0);
            checkOutput("sb_queue_nonempty", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
                sb_item = sbq.pop_front();
                checkOutput("sb_port", m1_done ? 1 : 0, sb_item.port);
                checkOutput("sb_rdata", m1_done ? m1_rdata : m0_rdata, sb_item.rdata);
                checkOutput("sb_err", m1_done ? m1_err : m0_err, sb_item.err);
                checkOutput("sb_other_err", m1_done ? m0_err : m1_err, 0);
            end
        end
    end

    initial begin
        int n, last, en_cnt;
        bit seen, prev_rdy;
        checks = 0; errors = 0;
        rst = 1'b1;
        m0_req = 0; m1_req = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        m0_write = 0; m1_write = 0; m0_stb = 0; m1_stb = 0;
        slave_hang = 0; slave_err = 0; slave_wait = 0;
        tick(); tick();
        checkOutput("rst_psel", psel, 0);
        checkOutput("rst_penable", penable, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_paddr", paddr, 0);
        checkOutput("rst_pstb", pstb, 0);
        checkOutput("rst_m0_rdata", m0_rdata, 0);
        checkOutput("rst_done", {m0_done, m1_done}, 0);
        rst = 1'b0;

        // Single port 0 read, zero-wait slave
        applyStimulus(0, 32'h8000_0000, 32'h0, 1'b0, 4'hF);
        expectDone(0, 32'hDEAD_BEEF, 1'b0);
        tick();
        checkOutput("t1_setup_psel", psel, 1);
        checkOutput("t1_setup_penable", penable, 0);
        checkOutput("t1_paddr", paddr, 32'h8000_0000);
        checkOutput("t1_pstb_read", pstb, 0);
        checkOutput("t1_busy", busy, 1);
        tick();
        checkOutput("t1_access_psel", psel, 1);
        checkOutput("t1_access_penable", penable, 1);
        tick();
        checkOutput("t1_m0_done", m0_done, 1);
        checkOutput("t1_m1_done", m1_done, 0);
        checkOutput("t1_busy_done", busy, 0);
        m0_req = 1'b0;
        tick(); tick();
        checkOutput("t1_idle_after", busy, 0);

        // Both ports requesting continuously from reset alternate 0,1,0,1...
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expectDone(0, 32'h7EAD_BEEF, 1'b0);
            expectDone(1, 32'h1EAD_BEFF, 1'b0);
        end
        applyStimulus(0, 32'h2000_0000, 32'h0, 1'b0, 4'h0);
        applyStimulus(1, 32'h4000_0010, 32'h0, 1'b0, 4'h0);
        n = 0; last = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick();
            if (m0_done || m1_done) begin
                checkOutput("alt_port", m1_done, n % 2);
                if (n > 0) checkOutput("alt_gap", c - last, 3);
                last = c;
                n++;
                if (n == 6) begin m0_req = 1'b0; m1_req = 1'b0; end
            end
        end
        checkOutput("alt_count", n, 6);
        tick();

        // Port 1 write with three wait states
        slave_wait = 3;
        applyStimulus(1, 32'h1000_0000, 32'h55, 1'b1, 4'h3);
        expectDone(1, 32'h1EAD_BEFF, 1'b0);
        tick();
        checkOutput("wr_setup_pwrite", pwrite, 1);
        checkOutput("wr_setup_pstb", pstb, 4'h3);
        checkOutput("wr_setup_pdata", pdata, 32'h55);
        en_cnt = 0; seen = 0; prev_rdy = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (m1_done) begin
                seen = 1'b1;
                checkOutput("wr_ready_prev_cycle", prev_rdy, 1);
                m1_req = 1'b0;
            end else if (penable) begin
                en_cnt++;
                checkOutput("wr_pdata_stable", pdata, 32'h55);
                checkOutput("wr_pstb_stable", pstb, 4'h3);
                checkOutput("wr_paddr_stable", paddr, 32'h1000_0000);
            end
            prev_rdy = pready;
        end
        checkOutput("wr_penable_cycles", en_cnt, 4);
        checkOutput("wr_done_seen", seen, 1);
        slave_wait = 0;

        // Port 1 read with slave error, then a normal transfer
        slave_err = 1'b1;
        applyStimulus(1, 32'h3000_0000, 32'h0, 1'b0, 4'hF);
        expectDone(1, 32'h6EAD_BEEF, 1'b1);
        waitDone(1, "rderr");
        slave_err = 1'b0;
        applyStimulus(0, 32'h2000_0000, 32'h0, 1'b0, 4'h0);
        expectDone(0, 32'h7EAD_BEEF, 1'b0);
        waitDone(0, "after_err");

        // Hung slave hits the 4-cycle timeout
        slave_hang = 1'b1;
        applyStimulus(0, 32'h4000_0000, 32'h0, 1'b0, 4'h0);
        expectDone(0, 32'h0, 1'b1);
        tick();
        en_cnt = 0; seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            tick();
            if (m0_done) begin
                seen = 1'b1;
                checkOutput("to_psel", psel, 0);
                checkOutput("to_busy", busy, 0);
                m0_req = 1'b0;
            end else if (penable) begin
                en_cnt++;
            end
        end
        checkOutput("to_access_cycles", en_cnt, 4);
        checkOutput("to_done_seen", seen, 1);

        // Reset during the second ACCESS cycle aborts silently
        applyStimulus(0, 32'h4000_0000, 32'h0, 1'b0, 4'h0);
        tick(); tick(); tick();
        checkOutput("rs_in_access", penable, 1);
        rst = 1'b1;
        tick();
        checkOutput("rs_psel", psel, 0);
        checkOutput("rs_penable", penable, 0);
        checkOutput("rs_busy", busy, 0);
        checkOutput("rs_m1_rdata", m1_rdata, 0);
        checkOutput("rs_m0_done", m0_done, 0);
        rst = 1'b0;
        m0_req = 1'b0;
        slave_hang = 1'b0;
        tick(); tick(); tick();
        checkOutput("rs_no_done", {m0_done, m1_done}, 0);

        // First tie after reset goes to port 0
        expectDone(0, 32'h7EAD_BEEF, 1'b0);
        expectDone(1, 32'h1EAD_BEFF, 1'b0);
        applyStimulus(0, 32'h2000_0000, 32'h0, 1'b0, 4'h0);
        applyStimulus(1, 32'h4000_0010, 32'h0, 1'b0, 4'h0);
        waitDone(0, "tie_p0");
        waitDone(1, "tie_p1");

        tick(); tick();
        checkOutput("sb_drain", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
